// File: rtl/tc_countdown_pkg.sv
// Shared types and constants for the countdown timer.
//   state_t    : IDLE (holding) / RUN (counting)
//   EVENTS_W   : width of the optional terminal-count event counter
//   EVENTS_MAX : saturation value of that counter
package tc_countdown_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int             EVENTS_W   = 8;
    localparam logic [EVENTS_W-1:0] EVENTS_MAX = 8'hFF;

endpackage

// File: rtl/tc_sat_sub.sv
// Combinational saturating subtract: o_diff = i_a - i_b, clamped at 0.
//   i_a    : minuend
//   i_b    : subtrahend
//   o_diff : difference, never wraps below zero
module tc_sat_sub #(
    parameter int BIT_WIDTH = 8
) (
    input  logic [BIT_WIDTH-1:0] i_a,
    input  logic [BIT_WIDTH-1:0] i_b,
    output logic [BIT_WIDTH-1:0] o_diff
);

    assign o_diff = (i_a > i_b) ? (i_a - i_b) : '0;

endmodule

// File: rtl/tc_countdown_timer.sv
// Down-counting timer with reload register and terminal-count pulse.
// All state updates on the falling edge of clk; rst is synchronous, active-low.
//   clk         : clock (falling-edge active)
//   rst         : synchronous active-low reset
//   load        : capture in into count and reload register (highest priority)
//   in          : start / reload value
//   enable      : count when high, hold when low
//   auto_reload : on terminal count, reload instead of stopping
//   out         : current count (registered)
//   zero        : one-cycle terminal-count pulse (registered)
//   busy        : high while in RUN
//   events      : zero-pulse count, saturating at 255, cleared by reset/load
//                 (present only when TC_COUNTDOWN_EVENTCNT_EN is defined)
module tc_countdown_timer
    import tc_countdown_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int STEP      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BIT_WIDTH-1:0] in,
    input  logic                 enable,
    input  logic                 auto_reload,
    output logic [BIT_WIDTH-1:0] out,
    output logic                 zero,
`ifdef TC_COUNTDOWN_EVENTCNT_EN
    output logic [EVENTS_W-1:0]  events,
`endif
    output logic                 busy
);

    localparam logic [BIT_WIDTH-1:0] STEP_V = BIT_WIDTH'(STEP);

    state_t               r_state,  w_state_nxt;
    logic [BIT_WIDTH-1:0] r_out,    w_out_nxt;
    logic [BIT_WIDTH-1:0] r_reload, w_reload_nxt;
    logic                 r_zero,   w_zero_nxt;
    logic [BIT_WIDTH-1:0] w_dec;

    tc_sat_sub #(.BIT_WIDTH(BIT_WIDTH)) u_dec (
        .i_a    (r_out),
        .i_b    (STEP_V),
        .o_diff (w_dec)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_reload_nxt = r_reload;
        w_zero_nxt   = 1'b0;
        if (load) begin
            // Loading 0 parks the timer in IDLE, so a zero reload value
            // can never be combined with auto-reload.
            w_reload_nxt = in;
            w_out_nxt    = in;
            w_state_nxt  = (in != '0) ? RUN : IDLE;
        end else if (r_state == RUN && enable) begin
            if (r_out == '0) begin
                // Only reachable after a pulse taken with auto_reload=1.
                if (auto_reload) w_out_nxt   = r_reload;
                else             w_state_nxt = IDLE;
            end else begin
                w_out_nxt = w_dec;
                if (w_dec == '0) begin
                    w_zero_nxt = 1'b1;
                    if (!auto_reload) w_state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_out    <= '0;
            r_reload <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_reload <= w_reload_nxt;
            r_zero   <= w_zero_nxt;
        end
    end

`ifdef TC_COUNTDOWN_EVENTCNT_EN
    logic [EVENTS_W-1:0] r_events;

    always_ff @(negedge clk) begin
        if (!rst || load)
            r_events <= '0;
        else if (w_zero_nxt && r_events != EVENTS_MAX)
            r_events <= r_events + 1'b1;
    end

    assign events = r_events;
`endif

    assign out  = r_out;
    assign zero = r_zero;
    assign busy = (r_state == RUN);

endmodule
